srl_prbs_checker: RTL and testbench

Self-synchronising PRBS7 stream checker for the receiving end of an SRL chain under test. It samples the chain output once per shift strobe and locks onto the pseudo-random sequence that the stimulus side writes into the chain. Once locked, it counts and flags bit errors. Reporting does not depend on the chain length, so one checker instance fits behind any SRL16/SRL32 chain segment in the SRL board tests.

---
 rtl/srl_test_pkg.sv | 19 +
 rtl/srl_err_counter.sv | 29 ++
 rtl/srl_prbs_checker.sv | 140 ++++++++++++++
 tb/tb_srl_prbs_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srl_test_pkg.sv
// Shared definitions for the SRL chain test blocks: PRBS7 constants, checker states.
package srl_test_pkg;

    localparam int unsigned PRBS_W = 7;
    localparam int unsigned TAP_A  = 6;
    localparam int unsigned TAP_B  = 5;

    typedef enum logic [1:0] {
        SEED    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } chk_state_e;

    // Next PRBS7 bit (x^7+x^6+1) predicted from the 7-bit history, newest bit in [0].
    function automatic logic prbs7_pred(input logic [PRBS_W-1:0] hist);
        return hist[TAP_A] ^ hist[TAP_B];
    endfunction

endpackage

// File: rtl/srl_err_counter.sv
// Saturating error counter with a sticky flag; clr wins over a coincident inc.
module srl_err_counter #(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 err_sticky
);

    // Count and flag errors; hold at all-ones once saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (inc) begin
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: rtl/srl_prbs_checker.sv
// Self-synchronising PRBS7 checker sampling an SRL chain output once per shift strobe.
module srl_prbs_checker
    import srl_test_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned UNLOCK_ERRS = 4,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sh,
    input  logic                 q,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 lost_lock,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned FILL_W  = 3;
    localparam int unsigned MATCH_W = 8;
    localparam int unsigned MISS_W  = 4;

    chk_state_e          state, state_nxt;
    logic [PRBS_W-1:0]   sr, sr_nxt;
    logic [FILL_W-1:0]   fill, fill_nxt;
    logic [MATCH_W-1:0]  match_cnt, match_nxt;
    logic [MISS_W-1:0]   miss_cnt, miss_nxt;
    logic                sh_d;

    logic                pred_c;
    logic                mismatch_c;
    logic                err_inc_c;
    logic                lost_nxt_c;
    logic                locked_nxt_c;

    assign pred_c     = prbs7_pred(sr);
    assign mismatch_c = q ^ pred_c;

    // State, history and counter registers plus registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEED;
            sr        <= '0;
            fill      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            sh_d      <= 1'b0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            lost_lock <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            fill      <= fill_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            sh_d      <= sh;
            locked    <= locked_nxt_c;
            err_pulse <= err_inc_c;
            lost_lock <= lost_nxt_c;
        end
    end

    // Next-state and datapath update, active only on a sample edge (sh_d high).
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        fill_nxt  = fill;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        if (sh_d) begin
            case (state)
                SEED: begin
                    sr_nxt   = {sr[PRBS_W-2:0], q};
                    fill_nxt = (fill == FILL_W'(PRBS_W)) ? fill : fill + FILL_W'(1);
                    // All-zero history is the LFSR lockup value and never seeds.
                    if (fill_nxt == FILL_W'(PRBS_W) && sr_nxt != '0) begin
                        state_nxt = LOCKING;
                        match_nxt = '0;
                    end
                end
                LOCKING: begin
                    sr_nxt = {sr[PRBS_W-2:0], q};
                    if (mismatch_c) begin
                        match_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + MATCH_W'(1);
                        if (match_nxt == MATCH_W'(LOCK_COUNT)) begin
                            state_nxt = LOCKED;
                            miss_nxt  = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so one flipped bit counts once.
                    sr_nxt = {sr[PRBS_W-2:0], pred_c};
                    if (mismatch_c) begin
                        miss_nxt = miss_cnt + MISS_W'(1);
                        if (miss_nxt == MISS_W'(UNLOCK_ERRS)) begin
                            state_nxt = SEED;
                            fill_nxt  = '0;
                            match_nxt = '0;
                            miss_nxt  = '0;
                        end
                    end else begin
                        miss_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = SEED;
                end
            endcase
        end
    end

    // Next values of the registered status outputs and the counter increment.
    always_comb begin
        err_inc_c    = 1'b0;
        lost_nxt_c   = 1'b0;
        locked_nxt_c = (state_nxt == LOCKED);
        if (sh_d && state == LOCKED) begin
            err_inc_c  = mismatch_c;
            lost_nxt_c = (state_nxt == SEED);
        end
    end

    srl_err_counter #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_err_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (err_inc_c),
        .clr        (clr),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
    );

endmodule

// File: tb/tb_srl_prbs_checker.sv
// Directed bench for srl_prbs_checker: default instance plus a 3-bit counter instance.
module tb_srl_prbs_checker;

    logic        clk;
    logic        rst_n;
    logic        sh;
    logic        q;
    logic        clr;

    logic        locked, err_pulse, lost_lock, err_sticky;
    logic [15:0] err_cnt;
    logic        locked3, err_pulse3, lost_lock3, err_sticky3;
    logic [2:0]  err_cnt3;

    int          n_cmp;
    int          n_bad;
    logic [6:0]  g;

    srl_prbs_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sh         (sh),
        .q          (q),
        .clr        (clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .lost_lock  (lost_lock),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    srl_prbs_checker #(
        .LOCK_COUNT  (16),
        .UNLOCK_ERRS (4),
        .ERR_CNT_W   (3)
    ) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sh         (sh),
        .q          (q),
        .clr        (clr),
        .locked     (locked3),
        .err_pulse  (err_pulse3),
        .lost_lock  (lost_lock3),
        .err_sticky (err_sticky3),
        .err_cnt    (err_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sh    = 1'b0;
        q     = 1'b0;
        clr   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Raise sh one cycle ahead so the next send lands on a sample edge.
    task automatic prime();
        @(negedge clk);
        sh = 1'b1;
        q  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One sample of the reference PRBS7 stream, optionally inverted, with sh held high.
    task automatic send(input logic flip, input logic clr_v);
        logic b;
        b = g[6] ^ g[5];
        g = {g[5:0], b};
        @(negedge clk);
        q   = b ^ flip;
        sh  = 1'b1;
        clr = clr_v;
        @(posedge clk);
        #1;
    endtask

    task automatic run_clean(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sh    = 1'b0;
        q     = 1'b0;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({locked, err_pulse, lost_lock, err_sticky, err_cnt} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", {locked, err_pulse, lost_lock, err_sticky, err_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_lock();
        int bad;
        do_reset();
        g = 7'h01;
        prime();
        run_clean(22);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_sample22: locked=%b want 0", locked);
        end
        send(1'b0, 1'b0);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_sample23: locked=%b want 1", locked);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            send(1'b0, 1'b0);
            if (locked !== 1'b1 || err_pulse !== 1'b0 || err_cnt !== 16'd0) bad++;
        end
        n_cmp++;
        if (bad != 0 || err_cnt !== 16'd0 || err_sticky !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_1000: bad_samples=%0d err_cnt=%0d sticky=%b want 0/0/0", bad, err_cnt, err_sticky);
        end
    endtask

    task automatic test_single_error();
        send(1'b1, 1'b0);
        n_cmp++;
        if ({err_pulse, err_sticky, locked, lost_lock} !== 4'b1110 || err_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL single_err: pulse/sticky/locked/lost=%b cnt=%0d want 1110 cnt=1",
                     {err_pulse, err_sticky, locked, lost_lock}, err_cnt);
        end
        send(1'b0, 1'b0);
        n_cmp++;
        if (err_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL single_err_pulse_width: err_pulse=%b want 0", err_pulse);
        end
        run_clean(50);
        n_cmp++;
        if (err_cnt !== 16'd1 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL single_err_after: err_cnt=%0d locked=%b want 1/1", err_cnt, locked);
        end
    endtask

    task automatic test_burst();
        send(1'b0, 1'b1);
        n_cmp++;
        if (err_cnt !== 16'd0 || err_sticky !== 1'b0 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL burst_clr: err_cnt=%0d sticky=%b locked=%b want 0/0/1", err_cnt, err_sticky, locked);
        end
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 1'b0);
            n_cmp++;
            if (err_pulse !== 1'b1 || lost_lock !== (i == 3) || locked !== (i != 3)) begin
                n_bad++;
                $display("FAIL burst_err%0d: pulse/lost/locked=%b%b%b want 1%b%b",
                         i, err_pulse, lost_lock, locked, (i == 3), (i != 3));
            end
        end
        n_cmp++;
        if (err_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL burst_count: err_cnt=%0d want 4", err_cnt);
        end
        send(1'b0, 1'b0);
        n_cmp++;
        if (lost_lock !== 1'b0) begin
            n_bad++;
            $display("FAIL burst_lost_width: lost_lock=%b want 0", lost_lock);
        end
        run_clean(21);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL relock_sample22: locked=%b want 0", locked);
        end
        send(1'b0, 1'b0);
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL relock_sample23: locked=%b err_cnt=%0d want 1/4", locked, err_cnt);
        end
    endtask

    task automatic test_all_zero();
        int bad;
        do_reset();
        bad = 0;
        q = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            sh = 1'b1;
            @(negedge clk);
            sh = 1'b0;
            repeat (2) @(negedge clk);
            if (locked !== 1'b0 || lost_lock !== 1'b0 || err_cnt !== 16'd0) bad++;
        end
        n_cmp++;
        if (bad != 0 || locked !== 1'b0 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL all_zero: bad_samples=%0d locked=%b err_cnt=%0d want 0/0/0", bad, locked, err_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        g = 7'h01;
        prime();
        run_clean(23);
        n_cmp++;
        if (locked3 !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_lock: locked3=%b want 1", locked3);
        end
        for (int i = 0; i < 20; i++) send((i % 2) == 0, 1'b0);
        n_cmp++;
        if (err_cnt3 !== 3'd7 || err_cnt !== 16'd10 || locked3 !== 1'b1 || err_sticky3 !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_count: cnt3=%0d cnt16=%0d locked3=%b sticky3=%b want 7/10/1/1",
                     err_cnt3, err_cnt, locked3, err_sticky3);
        end
        send(1'b1, 1'b1);
        n_cmp++;
        if (err_pulse3 !== 1'b1 || err_cnt3 !== 3'd0 || err_sticky3 !== 1'b0 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL clr_coincident: pulse3=%b cnt3=%0d sticky3=%b cnt16=%0d want 1/0/0/0",
                     err_pulse3, err_cnt3, err_sticky3, err_cnt);
        end
        send(1'b0, 1'b0);
        n_cmp++;
        if (err_cnt3 !== 3'd0 || err_sticky3 !== 1'b0 || locked3 !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_after: cnt3=%0d sticky3=%b locked3=%b want 0/0/1", err_cnt3, err_sticky3, locked3);
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        g = 7'h01;
        prime();
        run_clean(23);
        send(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sh    = 1'b0;
        #1;
        n_cmp++;
        if ({locked, err_pulse, lost_lock, err_sticky, err_cnt} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_mid_lock: outputs=%h want 0", {locked, err_pulse, lost_lock, err_sticky, err_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        prime();
        run_clean(22);
        n_cmp++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_relock22: locked=%b want 0", locked);
        end
        send(1'b0, 1'b0);
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_relock23: locked=%b err_cnt=%0d want 1/0", locked, err_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        g     = 7'h01;
        test_reset();
        test_clean_lock();
        test_single_error();
        test_burst();
        test_all_zero();
        test_saturation();
        test_reset_mid_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
